// File: rtl/instr_lane_receiver.sv
// rtl/instr_lane_receiver.sv - arbitrates host/maintenance instruction sequences and stripes them across lane FIFOs
module instr_lane_receiver #(
    parameter int         NUM_LANES   = 2,
    parameter int         FIFO_DEPTH  = 64,
    parameter int         INSTR_WIDTH = 32,
    parameter logic [3:0] END_OPCODE  = 4'hF,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dispatcher_ready,
    input  logic                             app_en,
    output logic                             app_ack,
    input  logic [INSTR_WIDTH-1:0]           app_instr,
    input  logic                             maint_en,
    output logic                             maint_ack,
    input  logic [INSTR_WIDTH-1:0]           maint_instr,
    input  logic [NUM_LANES-1:0]             lane_rd_en,
    output logic [NUM_LANES*INSTR_WIDTH-1:0] lane_dout,
    output logic [NUM_LANES-1:0]             lane_empty,
    output logic [NUM_LANES-1:0]             lane_full,
    output logic                             process_iseq,
    output logic                             maint_active,
    output logic [CNT_WIDTH-1:0]             seq_len
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNTF_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_APP, S_MAINT, S_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [LANE_W-1:0]        ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]     seq_len_q, seq_len_d;
    logic                     maint_active_q, maint_active_d;
    logic [INSTR_WIDTH-1:0]   src_instr;
    logic                     src_en, is_end, accept;
    logic [NUM_LANES-1:0]     lane_wr;

    always_comb begin
        src_en    = 1'b0;
        src_instr = app_instr;
        case (state_q)
            S_APP:   src_en = app_en;
            S_MAINT: begin
                src_en    = maint_en;
                src_instr = maint_instr;
            end
            default: ;
        endcase
        is_end = (src_instr[INSTR_WIDTH-1 -: 4] == END_OPCODE);
        // END is never stored, so it must not be held back by a full lane
        accept    = src_en & (is_end | ~lane_full[ptr_q]);
        app_ack   = accept & (state_q == S_APP);
        maint_ack = accept & (state_q == S_MAINT);
        lane_wr   = '0;
        lane_wr[ptr_q] = accept & ~is_end;
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        seq_len_d      = seq_len_q;
        maint_active_d = maint_active_q;
        case (state_q)
            S_IDLE: begin
                ptr_d = '0;
                if (dispatcher_ready && maint_en) begin
                    state_d        = S_MAINT;
                    maint_active_d = 1'b1;
                end else if (dispatcher_ready && app_en) begin
                    state_d = S_APP;
                end
            end
            S_APP, S_MAINT: begin
                if (accept) begin
                    if (is_end) begin
                        state_d = S_WAIT;
                    end else begin
                        ptr_d = (ptr_q == LANE_W'(NUM_LANES - 1)) ? '0 : ptr_q + 1'b1;
                        if (seq_len_q != '1) seq_len_d = seq_len_q + 1'b1;
                    end
                end
            end
            default: begin
                if (!dispatcher_ready) begin
                    state_d        = S_IDLE;
                    maint_active_d = 1'b0;
                    seq_len_d      = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            seq_len_q      <= '0;
            maint_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            seq_len_q      <= seq_len_d;
            maint_active_q <= maint_active_d;
        end
    end

    assign process_iseq = (state_q == S_WAIT);
    assign maint_active = maint_active_q;
    assign seq_len      = seq_len_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [INSTR_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CNTF_W-1:0]      count_q, count_d;
        logic                   do_rd;

        always_comb begin
            do_rd    = lane_rd_en[g] & (count_q != '0);
            wr_ptr_d = lane_wr[g] ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_d  = count_q;
            if (lane_wr[g] && !do_rd)      count_d = count_q + 1'b1;
            else if (!lane_wr[g] && do_rd) count_d = count_q - 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        always_ff @(posedge clk) begin
            if (lane_wr[g]) mem[wr_ptr_q] <= src_instr;
        end

        assign lane_dout[g*INSTR_WIDTH +: INSTR_WIDTH] = mem[rd_ptr_q];
        assign lane_empty[g] = (count_q == '0);
        assign lane_full[g]  = (count_q == CNTF_W'(FIFO_DEPTH));
    end
endmodule
